counter_arbiter_ctrl: RTL
=========================

Name: counter_arbiter_ctrl

Overview:
- Shares one 3-bit up/down mod-8 counter resource between two requesters, A and B.
- Each requester asks for a run of len steps in one direction: dir=1 counts up, dir=0 counts down.
- The block grants the counter round-robin, steps it once per cycle, then pulses done to the owner.
- It also drives the counter's mode/step control, so an external Moore counter can be slaved to it.

Parameters:
- LEN_W, 4, width of the step-count request fields.
- CNT_W, 3, counter width; the counter wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A wants the counter; held until done_a or abandoned.
- dir_a  input  1  A direction: 1 = up, 0 = down. Sampled at grant.
- len_a  input  LEN_W  A step count. Sampled at grant.
- req_b  input  1  requester B request.
- dir_b  input  1  B direction.
- len_b  input  LEN_W  B step count.
- gnt_a  output  1  A owns the counter; high while in RUN for A.
- gnt_b  output  1  B owns the counter.
- done_a  output  1  one-cycle pulse: A's run finished.
- done_b  output  1  one-cycle pulse: B's run finished.
- busy  output  1  state is not IDLE.
- step  output  1  counter advances at the next edge.
- mode  output  1  latched direction of the current run.
- count  output  CNT_W  current counter value.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, count 0, rem 0, owner A, priority A, all outputs 0.
- Reset mid-run aborts the run immediately. No done pulse is issued.
- FSM states: IDLE, RUN, DONE. Outputs are Moore-decoded from state, owner and rem; no input-to-output combinational path.
- IDLE:
  - Only one request: grant it.
  - Both requesting: grant the requester holding priority.
  - On the grant edge: latch owner, mode <= dir, rem <= len; go to RUN.
  - No request: stay in IDLE.
- RUN:
  - gnt_<owner> = 1.
  - step = (rem != 0).
  - Each edge with rem != 0: count <= count + 1 (mode=1) or count - 1 (mode=0), wrapping mod 2^CNT_W; rem <= rem - 1.
  - Edge with rem == 0: go to DONE.
- DONE:
  - done_<owner> = 1 for exactly one cycle; gnt drops.
  - Priority flips to the non-owner.
  - Next edge: go to IDLE.
- Abort: if req_<owner> is low at a RUN edge, go to IDLE.
  - count keeps its current value; no done pulse; priority still flips.
  - Abort is checked before the step on that edge, so no step occurs on it.
- Latency for len=N: request seen in IDLE at edge 0; RUN from edge 1; count changes at edges 2..N+1; DONE at edge N+2; IDLE at edge N+3.
- len=0: RUN for one cycle with step=0, then DONE. count is unchanged.
- Wrap-around: 7 up-step gives 0; 0 down-step gives 7. No saturation.
- Non-owner request while busy: ignored, held pending. It is re-arbitrated in IDLE on the next cycle after DONE/abort.
- A requester may not be re-granted in the IDLE cycle after its own DONE if the other is requesting.
- dir/len changes after grant have no effect.
- busy = (state != IDLE).
- gnt_a and gnt_b are never high together; done_a and done_b are never high together.

Optional Feature:
- Macro: COUNTER_LOAD_EN.
- Defined:
  - Adds ports load (input, 1) and load_val (input, CNT_W).
  - In IDLE with load=1 and no grant this cycle: count <= load_val at the edge.
  - If a request is also granted that cycle, load is ignored (the grant wins).
  - load is ignored in RUN/DONE.
- Undefined: the ports are absent; count is changed only by runs and reset.

Test Plan:
- Reset, then req_a=1, dir_a=1, len_a=3 → gnt_a high from edge 1; count 0→1→2→3 at edges 2,3,4; done_a pulses one cycle at edge 5; busy low at edge 6.
- count=1, req_b=1, dir_b=0, len_b=3 → count 1→0→7→6 (down wrap); done_b pulse; mode=0 throughout RUN.
- req_a and req_b both high from reset, len=2 each → A served first, B granted in the IDLE cycle after done_a; gnt_a and gnt_b never overlap; final count 4 (both up).
- A running len=5 up from 0; drop req_a after count=2 → state IDLE next edge; count stays 2; no done_a; next simultaneous request goes to B.
- len_a=0 → one RUN cycle with step=0, done_a pulse, count unchanged; rst_n pulsed low mid-run of a len=8 run → all outputs 0 immediately, count 0.
- COUNTER_LOAD_EN defined: load=1, load_val=5 in IDLE → count=5; then an up run with len=4 → count 1, exercising wrap.

Source files
------------

// File: rtl/counter_arbiter_ctrl.sv
// counter_arbiter_ctrl: round-robin owner of a shared mod-2^CNT_W up/down
// counter. A granted requester gets its run of len steps, one per cycle, then
// a single-cycle done pulse. Optional macro COUNTER_LOAD_EN adds an
// idle-time parallel load of the counter (load / load_val).
//
// state | meaning
// IDLE  | no run in progress; arbitrate requests (and load, if enabled)
// RUN   | counter owned; step once per cycle while rem != 0
// DONE  | run finished; done pulse to owner, priority moves to the other side
module counter_arbiter_ctrl #(
   parameter int LEN_W = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             dir_a,
   input  logic [LEN_W-1:0] len_a,
   input  logic             req_b,
   input  logic             dir_b,
   input  logic [LEN_W-1:0] len_b,
`ifdef COUNTER_LOAD_EN
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
`endif
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             done_a,
   output logic             done_b,
   output logic             busy,
   output logic             step,
   output logic             mode,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [LEN_W-1:0] LEN_ONE = 1;

   state_t           state;
   logic             owner;     // 0 = A, 1 = B
   logic             prio;      // 0 = A holds priority, 1 = B
   logic             mode_q;
   logic [LEN_W-1:0] rem;
   logic [CNT_W-1:0] count_q;

   logic want;
   logic pick_b;
   logic owner_req;

   // Arbitration: B wins only if A is absent or B holds priority.
   assign want      = req_a | req_b;
   assign pick_b    = req_b & (~req_a | prio);
   assign owner_req = owner ? req_b : req_a;

   // Controller state, run bookkeeping and the counter itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         owner   <= 1'b0;
         prio    <= 1'b0;
         mode_q  <= 1'b0;
         rem     <= '0;
         count_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (want) begin
                  owner  <= pick_b;
                  mode_q <= pick_b ? dir_b : dir_a;
                  rem    <= pick_b ? len_b : len_a;
                  state  <= RUN;
               end
`ifdef COUNTER_LOAD_EN
               else if (load) begin
                  count_q <= load_val;
               end
`endif
            end
            RUN: begin
               // Abandonment takes precedence over the step on the same edge.
               if (!owner_req) begin
                  state <= IDLE;
                  prio  <= ~owner;
               end else if (rem != '0) begin
                  count_q <= mode_q ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
                  rem     <= rem - LEN_ONE;
               end else begin
                  state <= DONE;
                  prio  <= ~owner;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Moore decode of the outputs from registered state only.
   assign gnt_a  = (state == RUN)  && !owner;
   assign gnt_b  = (state == RUN)  &&  owner;
   assign done_a = (state == DONE) && !owner;
   assign done_b = (state == DONE) &&  owner;
   assign busy   = (state != IDLE);
   assign step   = (state == RUN)  && (rem != '0);
   assign mode   = mode_q;
   assign count  = count_q;

endmodule
